// File: rtl/approx_mult_engine_if.sv
// Operand/result RAM ports and run handshake of the approximate multiplier engine.
// The engine takes the slave side; whoever starts runs and owns the RAMs takes the master side.
interface approx_mult_engine_if #(
    parameter int W      = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(2*DEPTH),
    parameter int CNT_W  = $clog2(DEPTH+1)
);
    logic              start;
    logic [CNT_W-1:0]  pair_count;
    logic              exact_mode;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [W-1:0]      rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [2*W-1:0]    wr_data;

    modport master (
        output start, pair_count, exact_mode, rd_data,
        input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  start, pair_count, exact_mode, rd_data,
        output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/approx_mult_engine.sv
// Normalise / truncate / denormalise multiplier: reads operand pairs from RAM, multiplies
// the top K bits of each leading-zero-normalised operand and writes realigned 2W-bit results.
//
// state  | meaning
// IDLE   | waiting for start; latches pair count and mode
// RD_A   | read request for operand A of pair i
// RD_B   | read request for operand B; A arrives
// LD_B   | B arrives
// NORM   | shift out leading zeros of A and B
// MUL    | multiply (truncated or exact), load realign count
// DENORM | shift product right once per cycle
// WRITE  | write result i
// DONE   | one-cycle done pulse
module approx_mult_engine #(
    parameter int W      = 16,
    parameter int K      = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(2*DEPTH),
    parameter int CNT_W  = $clog2(DEPTH+1)
) (
    input logic               clk,
    input logic               rst,
    approx_mult_engine_if.slave bus
);
    localparam int LZ_W = (W > 1) ? $clog2(W) : 1;
    localparam int SH_W = $clog2(2*W);

    typedef enum logic [3:0] {
        S_IDLE, S_RD_A, S_RD_B, S_LD_B, S_NORM, S_MUL, S_DENORM, S_WRITE, S_DONE
    } state_t;

    state_t state_q, state_nxt;

    logic [CNT_W-1:0] cnt_q;
    logic             exact_q;
    logic [CNT_W-1:0] idx_q;
    logic [W-1:0]     a_q, b_q;
    logic [LZ_W-1:0]  la_q, lb_q;
    logic [2*W-1:0]   p_q;
    logic [SH_W-1:0]  sh_q;

    logic             a_stop, b_stop, last_pair;
    logic [SH_W-1:0]  sh_load;
    logic [2*K-1:0]   prod_k;
    logic [2*W-1:0]   p_approx, p_exact;

    // A zero operand never sees its MSB set, so the counter cap is what stops it.
    assign a_stop    = a_q[W-1] | (la_q == LZ_W'(W-1));
    assign b_stop    = b_q[W-1] | (lb_q == LZ_W'(W-1));
    assign last_pair = ((idx_q + CNT_W'(1)) == cnt_q);
    assign sh_load   = exact_q ? '0 : (SH_W'(la_q) + SH_W'(lb_q));
    assign prod_k    = (2*K)'(a_q[W-1:W-K]) * (2*K)'(b_q[W-1:W-K]);
    assign p_approx  = (2*W)'(prod_k) << (2*W-2*K);
    assign p_exact   = (2*W)'(a_q) * (2*W)'(b_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_nxt;
    end

    always_comb begin
        state_nxt    = state_q;
        bus.busy     = (state_q != S_IDLE);
        bus.done     = 1'b0;
        bus.rd_en    = 1'b0;
        bus.rd_addr  = '0;
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) state_nxt = (bus.pair_count == '0) ? S_DONE : S_RD_A;
            end
            S_RD_A: begin
                bus.rd_en   = 1'b1;
                bus.rd_addr = ADDR_W'({idx_q, 1'b0});
                state_nxt   = S_RD_B;
            end
            S_RD_B: begin
                bus.rd_en   = 1'b1;
                bus.rd_addr = ADDR_W'({idx_q, 1'b1});
                state_nxt   = S_LD_B;
            end
            S_LD_B:   state_nxt = exact_q ? S_MUL : S_NORM;
            S_NORM:   if (a_stop && b_stop) state_nxt = S_MUL;
            S_MUL:    state_nxt = (sh_load != '0) ? S_DENORM : S_WRITE;
            S_DENORM: if (sh_q == SH_W'(1)) state_nxt = S_WRITE;
            S_WRITE: begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = ADDR_W'(idx_q);
                bus.wr_data = p_q;
                state_nxt   = last_pair ? S_DONE : S_RD_A;
            end
            S_DONE: begin
                bus.done  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            exact_q <= 1'b0;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            la_q    <= '0;
            lb_q    <= '0;
            p_q     <= '0;
            sh_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        cnt_q   <= bus.pair_count;
                        exact_q <= bus.exact_mode;
                        idx_q   <= '0;
                    end
                end
                S_RD_B: begin
                    a_q  <= bus.rd_data;
                    la_q <= '0;
                    lb_q <= '0;
                end
                S_LD_B: b_q <= bus.rd_data;
                S_NORM: begin
                    if (!a_stop) begin
                        a_q  <= a_q << 1;
                        la_q <= la_q + LZ_W'(1);
                    end
                    if (!b_stop) begin
                        b_q  <= b_q << 1;
                        lb_q <= lb_q + LZ_W'(1);
                    end
                end
                S_MUL: begin
                    p_q  <= exact_q ? p_exact : p_approx;
                    sh_q <= sh_load;
                end
                S_DENORM: begin
                    p_q  <= p_q >> 1;
                    sh_q <= sh_q - SH_W'(1);
                end
                S_WRITE: if (!last_pair) idx_q <= idx_q + CNT_W'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_approx_mult_engine.sv
// Directed bench for approx_mult_engine (W=16, K=8, DEPTH=8) with an operand RAM model.
module tb_approx_mult_engine;
    logic clk = 1'b0;
    logic rst = 1'b0;

    approx_mult_engine_if #(.W(16), .DEPTH(8)) bus();

    approx_mult_engine #(.W(16), .K(8), .DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [16];
    always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0]  rd_q [$];
    logic [3:0]  wa_q [$];
    logic [31:0] wd_q [$];
    int          lat_q [$];
    int busy_n, done_n, done_cyc, overlap_n, wr_rst;
    logic post_done, post_busy;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observes one run cycle by cycle; optional start pulse mid-run and reset abort.
    task automatic run_job(input int cnt, input bit ex, input int mid_start, input int abort_cyc);
        int cyc = 0;
        int t_rda = 0;
        bit fin = 0;
        bit aborted = 0;
        rd_q.delete(); wa_q.delete(); wd_q.delete(); lat_q.delete();
        busy_n = 0; done_n = 0; done_cyc = 0; overlap_n = 0; wr_rst = 0;
        @(negedge clk);
        bus.pair_count = 4'(cnt);
        bus.exact_mode = ex;
        bus.start      = 1'b1;
        while (!fin) begin
            @(negedge clk);
            cyc++;
            bus.start = (cyc == mid_start);
            if (bus.rd_en) begin
                rd_q.push_back(bus.rd_addr);
                if (!bus.rd_addr[0]) t_rda = cyc;
            end
            if (bus.wr_en) begin
                wa_q.push_back(bus.wr_addr);
                wd_q.push_back(bus.wr_data);
                lat_q.push_back(cyc - t_rda + 1);
            end
            if (bus.busy) busy_n++;
            if (bus.rd_en && bus.wr_en) overlap_n++;
            if (bus.done) begin
                done_n++;
                done_cyc = cyc;
                fin = 1;
            end
            if (cyc == abort_cyc) begin
                rst = 1'b0;
                #1;
                check_val("abort_outputs",
                          {bus.busy, bus.done, bus.rd_en, bus.wr_en, bus.rd_addr, bus.wr_addr},
                          '0);
                check_val("abort_wr_data", bus.wr_data, 0);
                repeat (3) begin
                    @(negedge clk);
                    if (bus.wr_en) wr_rst++;
                end
                rst = 1'b1;
                fin = 1;
                aborted = 1;
            end
            if (!fin && cyc >= 500) begin
                check_val("run_timeout", 64'(cyc), 0);
                fin = 1;
            end
        end
        bus.start = 1'b0;
        if (!aborted) begin
            @(negedge clk);
            post_done = bus.done;
            post_busy = bus.busy;
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.pair_count = '0;
        bus.exact_mode = 1'b0;
        bus.rd_data = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;

        repeat (3) @(negedge clk);
        check_val("reset_ctrl", {bus.busy, bus.done, bus.rd_en, bus.wr_en}, 4'b0000);
        check_val("reset_data", {bus.rd_addr, bus.wr_addr, bus.wr_data}, 0);
        rst = 1'b1;

        // small operands: deep normalisation on both sides
        mem[0] = 16'h0003; mem[1] = 16'h0005;
        run_job(1, 0, 0, 0);
        check_val("t1_nwr", wa_q.size(), 1);
        check_val("t1_addr", wa_q[0], 0);
        check_val("t1_data", wd_q[0], 32'h0000_000F);
        check_val("t1_lat", lat_q[0], 47);
        check_val("t1_done", {done_n[3:0], post_done, post_busy}, {4'd1, 1'b0, 1'b0});
        check_val("t1_overlap", overlap_n, 0);

        // two pairs: no shift, then mixed shifts
        mem[0] = 16'hFFFF; mem[1] = 16'hFFFF; mem[2] = 16'h1234; mem[3] = 16'h00FF;
        run_job(2, 0, 0, 0);
        check_val("t2_nwr", wa_q.size(), 2);
        check_val("t2_data0", wd_q[0], 32'hFE01_0000);
        check_val("t2_data1", wd_q[1], 32'h0012_0DE0);
        check_val("t2_addr", {wa_q[0], wa_q[1]}, {4'd0, 4'd1});
        check_val("t2_lat0", lat_q[0], 6);
        check_val("t2_lat1", lat_q[1], 25);
        check_val("t2_rd_n", rd_q.size(), 4);
        check_val("t2_rd_seq", {rd_q[0], rd_q[1], rd_q[2], rd_q[3]}, {4'd0, 4'd1, 4'd2, 4'd3});

        // same job with a start pulse mid-run
        run_job(2, 0, 3, 0);
        check_val("t6_nwr", wa_q.size(), 2);
        check_val("t6_data", {wd_q[0], wd_q[1]}, {32'hFE01_0000, 32'h0012_0DE0});
        check_val("t6_post_busy", post_busy, 0);

        // zero operand hits the counter cap
        mem[0] = 16'h0000; mem[1] = 16'h1234;
        run_job(1, 0, 0, 0);
        check_val("t3_data", wd_q[0], 0);
        check_val("t3_lat", lat_q[0], 39);

        // exact mode bypasses normalisation
        mem[0] = 16'h1234; mem[1] = 16'h00FF;
        run_job(1, 1, 0, 0);
        check_val("t4_data", wd_q[0], 32'h0012_21CC);
        check_val("t4_lat", lat_q[0], 5);

        // empty run
        run_job(0, 0, 0, 0);
        check_val("t5_rd_wr", {rd_q.size(), wa_q.size()}, 64'd0);
        check_val("t5_done_cyc", done_cyc, 1);
        check_val("t5_busy_n", busy_n, 1);
        check_val("t5_post", {post_done, post_busy}, 2'b00);

        // abort during DENORM of pair 1, then rerun
        mem[0] = 16'hFFFF; mem[1] = 16'hFFFF; mem[2] = 16'h0003; mem[3] = 16'h0005;
        mem[4] = 16'h8000; mem[5] = 16'h4000;
        run_job(3, 0, 0, 30);
        check_val("t7_nwr_before", wa_q.size(), 1);
        check_val("t7_wr_in_rst", wr_rst, 0);
        run_job(3, 0, 0, 0);
        check_val("t7_nwr", wa_q.size(), 3);
        check_val("t7_data", {wd_q[0], wd_q[1], wd_q[2]},
                  {32'hFE01_0000, 32'h0000_000F, 32'h2000_0000});
        check_val("t7_addr", {wa_q[0], wa_q[1], wa_q[2]}, {4'd0, 4'd1, 4'd2});
        check_val("t7_lat2", lat_q[2], 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
